// File: rtl/pcie_pkg.sv
// Shared definitions for the PCIe-path stream dispatch logic.
// Holds the rotating-priority pick used by the lane selector and the
// statistics counter type.
package pcie_pkg;

  // Upper bound on lane count the rotating pick can scan.
  localparam int unsigned RR_MAX_LANES = 64;
  localparam int unsigned RR_IDX_W     = 6;

  localparam int unsigned STAT_W = 32;
  typedef logic [STAT_W-1:0] stat_cnt_t;

  // Returns the first set bit of mask[nb-1:0], scanning start, start+1, ...
  // modulo nb. nb must be a power of two. When no bit is set the result is
  // start (callers qualify it with their own any-set flag).
  function automatic int unsigned rr_first_set(
    input logic [RR_MAX_LANES-1:0] mask,
    input int unsigned             nb,
    input int unsigned             start
  );
    int unsigned         pick;
    logic                found;
    logic [RR_IDX_W-1:0] idx;
    pick  = start & (nb - 1);
    found = 1'b0;
    for (int unsigned i = 0; i < RR_MAX_LANES; i++) begin
      idx = RR_IDX_W'((start + i) & (nb - 1));
      if (!found && (i < nb) && mask[idx]) begin
        pick  = 32'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/st_rr_free_select.sv
// Combinational round-robin selector: picks the first free lane starting at
// rr_ptr and reports whether any lane is free at all.
module st_rr_free_select
  import pcie_pkg::*;
#(
  parameter  int NB_OUT = 4,
  localparam int LANE_W = $clog2(NB_OUT)
) (
  input  logic [NB_OUT-1:0] lane_free,
  input  logic [LANE_W-1:0] rr_ptr,
  output logic [LANE_W-1:0] sel,
  output logic              any_free
);

  logic [RR_MAX_LANES-1:0] mask_ext;

  // Widen the free mask to the package scan width and pick the next lane.
  always_comb begin
    mask_ext                = '0;
    mask_ext[NB_OUT-1:0]    = lane_free;
    sel                     = LANE_W'(rr_first_set(mask_ext, 32'(NB_OUT), 32'(rr_ptr)));
    any_free                = |lane_free;
  end

endmodule

// File: rtl/st_ordered_dispatcher.sv
// Ordered dispatcher: spreads one input stream over NB_OUT lanes in
// round-robin order (skipping busy lanes) and emits, for every beat, the lane
// id it went to on the order stream so a downstream ordered mux can rebuild
// the original sequence. Lane and order outputs are registered (1-cycle
// latency). A beat is accepted only when the order register can take its
// token, so tokens and beats are always produced together.
// Optional per-lane beat counters on stat_beats: define ST_DISPATCH_STATS_EN.
module st_ordered_dispatcher
  import pcie_pkg::*;
#(
  parameter  int NB_OUT = 4,
  parameter  int DWIDTH = 250,
  localparam int LANE_W = $clog2(NB_OUT)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DWIDTH-1:0]              in_data,
  output logic [NB_OUT-1:0]              out_valid,
  input  logic [NB_OUT-1:0]              out_ready,
  output logic [NB_OUT-1:0][DWIDTH-1:0]  out_data,
  output logic                           order_valid,
  input  logic                           order_ready,
  output logic [LANE_W-1:0]              order_data
`ifdef ST_DISPATCH_STATS_EN
  ,
  output logic [NB_OUT-1:0][STAT_W-1:0]  stat_beats
`endif
);

  typedef logic [LANE_W-1:0] lane_id_t;

  if (NB_OUT < 2 || (NB_OUT & (NB_OUT - 1)) != 0 || NB_OUT > RR_MAX_LANES) begin : g_bad_nb_out
    $error("st_ordered_dispatcher: NB_OUT must be a power of two between 2 and 64");
  end

  logic [NB_OUT-1:0]             out_valid_q, out_valid_d;
  logic [NB_OUT-1:0][DWIDTH-1:0] out_data_q, out_data_d;
  logic                          order_valid_q, order_valid_d;
  lane_id_t                      order_data_q, order_data_d;
  lane_id_t                      rr_ptr_q, rr_ptr_d;

  logic [NB_OUT-1:0] lane_free;
  logic              order_free;
  logic              any_free;
  lane_id_t          sel;
  logic              accept;

  // A lane (or the order register) can take a new beat if empty or draining now.
  assign lane_free  = ~out_valid_q | out_ready;
  assign order_free = ~order_valid_q | order_ready;

  st_rr_free_select #(
    .NB_OUT (NB_OUT)
  ) u_sel (
    .lane_free (lane_free),
    .rr_ptr    (rr_ptr_q),
    .sel       (sel),
    .any_free  (any_free)
  );

  // Ready depends only on downstream state so it never loops back through in_valid.
  assign in_ready = order_free & any_free;
  assign accept   = in_valid & in_ready;

  // Next state: drain on downstream ready, load wins over drain on accept.
  always_comb begin
    out_valid_d   = out_valid_q & ~out_ready;
    out_data_d    = out_data_q;
    order_valid_d = order_valid_q & ~order_ready;
    order_data_d  = order_data_q;
    rr_ptr_d      = rr_ptr_q;
    if (accept) begin
      out_valid_d[sel] = 1'b1;
      out_data_d[sel]  = in_data;
      order_valid_d    = 1'b1;
      order_data_d     = sel;
      rr_ptr_d         = sel + lane_id_t'(1);
    end
  end

  // Control state: cleared on reset so in-flight beats and tokens are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= '0;
      order_valid_q <= 1'b0;
      rr_ptr_q      <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      order_valid_q <= order_valid_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  // Payload registers carry no reset; they are qualified by the valid bits.
  always_ff @(posedge clk) begin
    out_data_q   <= out_data_d;
    order_data_q <= order_data_d;
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign order_valid = order_valid_q;
  assign order_data  = order_data_q;

`ifdef ST_DISPATCH_STATS_EN
  logic [NB_OUT-1:0][STAT_W-1:0] stat_q, stat_d;

  // Count accepted beats per lane; counters wrap naturally.
  always_comb begin
    stat_d = stat_q;
    if (accept) begin
      stat_d[sel] = stat_q[sel] + STAT_W'(1);
    end
  end

  // Statistics register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_beats = stat_q;
`else
  // Statistics disabled: no counters and no stat_beats port.
`endif

endmodule

// File: tb/tb_st_ordered_dispatcher.sv
// Bench for st_ordered_dispatcher: directed scenarios with literal expectations,
// a per-cycle behavioural model of lane occupancy / token stream, and an
// ordered-mux reassembly scoreboard that rebuilds the input order from the
// lane outputs and the order tokens.
`timescale 1ns/1ps
module tb_st_ordered_dispatcher;

  localparam int NB = 4;
  localparam int DW = 250;
  localparam int LW = 2;

  typedef logic [DW-1:0] beat_t;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  beat_t                 in_data;
  logic [NB-1:0]         out_valid;
  logic [NB-1:0]         out_ready;
  logic [NB-1:0][DW-1:0] out_data;
  logic                  order_valid;
  logic                  order_ready;
  logic [LW-1:0]         order_data;
`ifdef ST_DISPATCH_STATS_EN
  logic [NB-1:0][31:0]   stat_beats;
`endif

  st_ordered_dispatcher #(
    .NB_OUT (NB),
    .DWIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .order_valid (order_valid),
    .order_ready (order_ready),
    .order_data  (order_data)
`ifdef ST_DISPATCH_STATS_EN
    ,
    .stat_beats  (stat_beats)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: lane contents, pending token, rotate start.
  logic  m_v [NB];
  beat_t m_d [NB];
  logic  m_ov;
  int    m_od;
  int    m_ptr;

  // Reassembly scoreboard.
  beat_t exp_q [$];
  beat_t lane_q [NB][$];
  int    tok_q [$];
  int    n_reasm;

  function automatic beat_t mk(int k);
    beat_t v;
    v          = '0;
    v[31:0]    = 32'hD000_0000 + k;
    v[249:218] = ~k;
    v[150:119] = 32'h5A5A_0000 ^ k;
    return v;
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, scoreboard logging, then model advance.
  task automatic cycle_check();
    int  sel;
    bit  ofree, exp_rdy, acc;
    logic [NB-1:0] mv_vec;
    if (!rst_n) begin
      for (int l = 0; l < NB; l++) begin
        m_v[l] = 1'b0;
        lane_q[l].delete();
      end
      m_ov    = 1'b0;
      m_ptr   = 0;
      exp_q.delete();
      tok_q.delete();
      n_reasm = 0;
      return;
    end
    ofree = !m_ov || order_ready;
    sel   = -1;
    for (int k = 0; k < NB; k++) begin
      int l;
      l = (m_ptr + k) % NB;
      if (sel < 0 && (!m_v[l] || out_ready[l])) sel = l;
    end
    exp_rdy = ofree && (sel >= 0);
    for (int l = 0; l < NB; l++) mv_vec[l] = m_v[l];
    chk("m_in_ready", 256'(in_ready), 256'(exp_rdy));
    chk("m_out_valid", 256'(out_valid), 256'(mv_vec));
    chk("m_order_valid", 256'(order_valid), 256'(m_ov));
    if (m_ov) chk("m_order_data", 256'(order_data), 256'(m_od));
    for (int l = 0; l < NB; l++)
      if (m_v[l]) chk("m_out_data", 256'(out_data[l]), 256'(m_d[l]));

    if (in_valid && in_ready) exp_q.push_back(in_data);
    for (int l = 0; l < NB; l++)
      if (out_valid[l] && out_ready[l]) lane_q[l].push_back(out_data[l]);
    if (order_valid && order_ready) tok_q.push_back(int'(order_data));
    while (tok_q.size() > 0 && lane_q[tok_q[0]].size() > 0) begin
      beat_t got;
      int    t;
      t   = tok_q.pop_front();
      got = lane_q[t].pop_front();
      chk("reasm_have_input", 256'(exp_q.size() > 0), 256'(1));
      if (exp_q.size() > 0) chk("reasm_data", 256'(got), 256'(exp_q.pop_front()));
      n_reasm++;
    end

    acc = in_valid && exp_rdy;
    for (int l = 0; l < NB; l++) begin
      if (acc && l == sel) begin
        m_v[l] = 1'b1;
        m_d[l] = in_data;
      end else if (out_ready[l]) begin
        m_v[l] = 1'b0;
      end
    end
    if (acc) begin
      m_ov  = 1'b1;
      m_od  = sel;
      m_ptr = (sel + 1) % NB;
    end else if (order_ready) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_l2 [7] = '{0, 1, 2, 3, 0, 2, 3};
    int exp_l4 [4] = '{2, 3, 0, 1};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = '1;
    order_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_order_valid", 256'(order_valid), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(1));

    // 1: back-to-back with everything ready.
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = mk(k);
      #1;
      chk("t1_in_ready", 256'(in_ready), 256'(1));
      tick();
      chk("t1_token", 256'(order_data), 256'(k % 4));
      chk("t1_lane_valid", 256'(out_valid), 256'(1 << (k % 4)));
      chk("t1_lane_data", 256'(out_data[k % 4]), 256'(mk(k)));
    end
    in_valid = 1'b0;
    tick();
    chk("t1_drained_lanes", 256'(out_valid), 256'(0));
    chk("t1_drained_order", 256'(order_valid), 256'(0));

    // 2: lane 1 stalled while holding a beat; it gets skipped.
    out_ready = 4'b1101;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_data  = mk(100 + k);
      tick();
      chk("t2_token", 256'(order_data), 256'(exp_l2[k]));
    end
    chk("t2_lane1_held", 256'(out_valid[1]), 256'(1));
    chk("t2_lane1_data", 256'(out_data[1]), 256'(mk(101)));
    in_valid  = 1'b0;
    out_ready = 4'hF;
    tick();
    tick();

    // 3: order consumer stalls with a token pending.
    in_valid = 1'b1;
    in_data  = mk(200);
    tick();
    chk("t3_first_token", 256'(order_data), 256'(0));
    order_ready = 1'b0;
    in_data     = mk(201);
    #1;
    chk("t3_stall_ready", 256'(in_ready), 256'(0));
    tick();
    chk("t3_no_load", 256'(out_valid), 256'(0));
    chk("t3_token_held", 256'(order_valid), 256'(1));
    tick();
    chk("t3_still_no_load", 256'(out_valid), 256'(0));
    order_ready = 1'b1;
    #1;
    chk("t3_resume_ready", 256'(in_ready), 256'(1));
    tick();
    chk("t3_resume_token", 256'(order_data), 256'(1));
    chk("t3_resume_valid", 256'(order_valid), 256'(1));
    chk("t3_resume_lane", 256'(out_valid), 256'(4'b0010));
    in_valid = 1'b0;
    tick();

    // 4: all lanes full and stalled, then only lane 3 released.
    out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = mk(300 + k);
      tick();
      chk("t4_token", 256'(order_data), 256'(exp_l4[k]));
    end
    chk("t4_all_full", 256'(out_valid), 256'(4'hF));
    in_data = mk(304);
    #1;
    chk("t4_full_ready", 256'(in_ready), 256'(0));
    tick();
    chk("t4_full_hold", 256'(out_valid), 256'(4'hF));
    chk("t4_order_drained", 256'(order_valid), 256'(0));
    chk("t4_lane2_kept", 256'(out_data[2]), 256'(mk(300)));
    out_ready = 4'b1000;
    #1;
    chk("t4_release_ready", 256'(in_ready), 256'(1));
    tick();
    chk("t4_release_token", 256'(order_data), 256'(3));
    chk("t4_release_data", 256'(out_data[3]), 256'(mk(304)));
    chk("t4_release_valid", 256'(out_valid), 256'(4'hF));
    in_valid  = 1'b0;
    out_ready = 4'hF;
    tick();
    tick();

    // 5: asynchronous reset in the middle of a burst.
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_data  = mk(400 + k);
      tick();
    end
    in_data = mk(402);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_lanes", 256'(out_valid), 256'(0));
    chk("t5_async_order", 256'(order_valid), 256'(0));
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = mk(410);
    tick();
    chk("t5_after_rst_token", 256'(order_data), 256'(0));
    chk("t5_after_rst_lane", 256'(out_valid), 256'(4'b0001));
    in_valid = 1'b0;
    tick();

    // 6: fresh reset, ten beats all ready.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = mk(500 + k);
      tick();
      chk("t6_token", 256'(order_data), 256'(k % 4));
    end
    in_valid = 1'b0;
    tick();
    tick();
`ifdef ST_DISPATCH_STATS_EN
    chk("t6_stat0", 256'(stat_beats[0]), 256'(3));
    chk("t6_stat1", 256'(stat_beats[1]), 256'(3));
    chk("t6_stat2", 256'(stat_beats[2]), 256'(2));
    chk("t6_stat3", 256'(stat_beats[3]), 256'(2));
`endif
    tick();
    chk("sb_reassembled", 256'(n_reasm), 256'(10));
    chk("sb_inputs_left", 256'(exp_q.size()), 256'(0));
    chk("sb_tokens_left", 256'(tok_q.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
